camera_st_source: RTL and testbench

Converts the camera's RGB565 pixel stream into Avalon-ST Video packets for the video scaler's sink. Every frame produces one control packet (width/height) followed by one video packet. Pixels are buffered in a small FIFO so the camera side is never stalled, and packets stay well-formed under backpressure or overflow. Sits between the camera capture logic and the `vga_demo` system's `video_scaler_0_avalon_scaler_sink_*` ports.

---
 rtl/camera_st_source.sv | 199 +++++++++++++++++++
 tb/tb_camera_st_source.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_st_source.sv
// RGB565 camera stream to Avalon-ST Video. Each frame becomes a control packet
// followed by a video packet, with a small pixel FIFO absorbing sink backpressure.
module camera_st_source #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        src_ready,
    output logic        src_valid,
    output logic [29:0] src_data,
    output logic        src_startofpacket,
    output logic        src_endofpacket,
    output logic        overflow,
    output logic        busy
);

    localparam longint unsigned TOTAL = longint'(WIDTH) * longint'(HEIGHT);
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] W16 = 16'(WIDTH);
    localparam logic [15:0] H16 = 16'(HEIGHT);

    typedef enum logic [1:0] {IDLE, CTRL, VHDR, PIX} state_t;

    state_t           state, state_n;
    logic [1:0]       ctrl_idx, ctrl_idx_n;
    logic             valid_n, sop_n, eop_n;
    logic [29:0]      data_n;
    logic [CNT_W-1:0] rd_cnt, rd_cnt_n, wr_cnt;
    logic             wr_en;
    logic             load, pop, start, wr_fire, wr_ok;

    logic [15:0]      mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full;
    logic [15:0]      head;

    // Each 4-bit nibble sits in the low bits of its 10-bit symbol.
    function automatic logic [29:0] sym3(input logic [3:0] s2, input logic [3:0] s1,
                                         input logic [3:0] s0);
        return {6'b0, s2, 6'b0, s1, 6'b0, s0};
    endfunction

    function automatic logic [29:0] expand(input logic [15:0] p);
        return {p[15:11], p[15:11], p[10:5], p[10:7], p[4:0], p[4:0]};
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = mem[rd_ptr[AW-1:0]];
    assign busy       = (state != IDLE);

    // A full FIFO still accepts a write when the same cycle pops the head.
    assign wr_fire = pix_valid && wr_en;
    assign wr_ok   = wr_fire && (!fifo_full || pop);

    always_comb begin
        state_n    = state;
        ctrl_idx_n = ctrl_idx;
        valid_n    = src_valid;
        data_n     = src_data;
        sop_n      = src_startofpacket;
        eop_n      = src_endofpacket;
        rd_cnt_n   = rd_cnt;
        pop        = 1'b0;
        start      = 1'b0;
        load       = !src_valid || src_ready;

        case (state)
            IDLE: begin
                valid_n = 1'b0;
                data_n  = 30'h0;
                sop_n   = 1'b0;
                eop_n   = 1'b0;
                if (frame_start) begin
                    start      = 1'b1;
                    state_n    = CTRL;
                    ctrl_idx_n = 2'd1;
                    rd_cnt_n   = '0;
                    valid_n    = 1'b1;
                    data_n     = 30'h0000000F;
                    sop_n      = 1'b1;
                end
            end
            CTRL: begin
                if (load) begin
                    valid_n    = 1'b1;
                    sop_n      = 1'b0;
                    eop_n      = (ctrl_idx == 2'd3);
                    ctrl_idx_n = ctrl_idx + 2'd1;
                    case (ctrl_idx)
                        2'd1:    data_n = sym3(W16[7:4], W16[11:8], W16[15:12]);
                        2'd2:    data_n = sym3(H16[11:8], H16[15:12], W16[3:0]);
                        default: data_n = sym3(4'h3, H16[3:0], H16[7:4]);
                    endcase
                    if (ctrl_idx == 2'd3) begin
                        state_n = VHDR;
                    end
                end
            end
            VHDR: begin
                if (load) begin
                    valid_n = 1'b1;
                    data_n  = 30'h0;
                    sop_n   = 1'b1;
                    eop_n   = 1'b0;
                    state_n = PIX;
                end
            end
            default: begin
                // Once every beat has been loaded, the next free slot means the EOP beat left.
                if (load) begin
                    sop_n = 1'b0;
                    if (rd_cnt == TOTAL_C) begin
                        valid_n = 1'b0;
                        data_n  = 30'h0;
                        eop_n   = 1'b0;
                        state_n = IDLE;
                    end else if (!fifo_empty) begin
                        pop      = 1'b1;
                        valid_n  = 1'b1;
                        data_n   = expand(head);
                        eop_n    = (rd_cnt == LAST_C);
                        rd_cnt_n = rd_cnt + CNT_W'(1);
                    end else if (!wr_en) begin
                        valid_n  = 1'b1;
                        data_n   = 30'h0;
                        eop_n    = (rd_cnt == LAST_C);
                        rd_cnt_n = rd_cnt + CNT_W'(1);
                    end else begin
                        valid_n = 1'b0;
                        eop_n   = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state             <= IDLE;
            ctrl_idx          <= 2'd0;
            src_valid         <= 1'b0;
            src_data          <= 30'h0;
            src_startofpacket <= 1'b0;
            src_endofpacket   <= 1'b0;
            rd_cnt            <= '0;
            wr_cnt            <= '0;
            wr_en             <= 1'b0;
            overflow          <= 1'b0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
        end else begin
            state             <= state_n;
            ctrl_idx          <= ctrl_idx_n;
            src_valid         <= valid_n;
            src_data          <= data_n;
            src_startofpacket <= sop_n;
            src_endofpacket   <= eop_n;
            rd_cnt            <= rd_cnt_n;
            if (start) begin
                wr_en    <= 1'b1;
                wr_cnt   <= '0;
                overflow <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + (AW+1)'(1);
                end
                if (wr_ok) begin
                    wr_ptr <= wr_ptr + (AW+1)'(1);
                    wr_cnt <= wr_cnt + CNT_W'(1);
                    if (wr_cnt == LAST_C) begin
                        wr_en <= 1'b0;
                    end
                end else if (wr_fire) begin
                    // An overflow discards the rest of the frame; the reader pads instead.
                    overflow <= 1'b1;
                    wr_en    <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= pix_data;
        end
    end

endmodule

// File: tb/tb_camera_st_source.sv
// Scoreboard bench for camera_st_source at WIDTH=4, HEIGHT=2, FIFO_DEPTH=4:
// stimulus pushes expected beats, a negedge monitor compares every presented beat.
module tb_camera_st_source;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [29:0] data;
    } beatT;

    logic        clock;
    logic        reset_reset_n;
    logic        frameStart;
    logic        pixValid;
    logic [15:0] pixData;
    logic        src_ready;
    logic        src_valid;
    logic [29:0] src_data;
    logic        src_startofpacket;
    logic        src_endofpacket;
    logic        overflow;
    logic        busy;

    beatT        expQueue [$];
    logic [15:0] pixTab [8];
    logic [29:0] expTab [8];
    int          checkCount = 0;
    int          errorCount = 0;
    int          xferCount  = 0;
    int          frameBase  = 0;
    int          readyMode  = 0;

    camera_st_source #(
        .WIDTH(4),
        .HEIGHT(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_clk(clock),
        .reset_reset_n(reset_reset_n),
        .frame_start(frameStart),
        .pix_valid(pixValid),
        .pix_data(pixData),
        .src_ready(src_ready),
        .src_valid(src_valid),
        .src_data(src_data),
        .src_startofpacket(src_startofpacket),
        .src_endofpacket(src_endofpacket),
        .overflow(overflow),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_valid"}, {31'b0, src_valid}, 32'd0);
        checkOutput({name, "_data"}, {2'b0, src_data}, 32'd0);
        checkOutput({name, "_sop"}, {31'b0, src_startofpacket}, 32'd0);
        checkOutput({name, "_eop"}, {31'b0, src_endofpacket}, 32'd0);
        checkOutput({name, "_overflow"}, {31'b0, overflow}, 32'd0);
        checkOutput({name, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    // Control packet for 4x2 progressive, video header, then eight pixel beats.
    task automatic pushFrame(input bit ovf);
        beatT b;
        expQueue.push_back({1'b1, 1'b0, 30'h0000000F});
        expQueue.push_back({1'b0, 1'b0, 30'h00000000});
        expQueue.push_back({1'b0, 1'b0, 30'h00000004});
        expQueue.push_back({1'b0, 1'b1, 30'h00300800});
        expQueue.push_back({1'b1, 1'b0, 30'h00000000});
        for (int i = 0; i < 8; i++) begin
            b.sop  = 1'b0;
            b.eop  = (i == 7);
            b.data = (ovf && i >= 4) ? 30'h0 : expTab[i];
            expQueue.push_back(b);
        end
    endtask

    task automatic applyStimulus(input int spacing, input int restartAt);
        @(posedge clock); #1;
        frameStart = 1'b1;
        @(posedge clock); #1;
        frameStart = 1'b0;
        checkOutput("start_busy", {31'b0, busy}, 32'd1);
        checkOutput("start_overflow", {31'b0, overflow}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            pixValid   = 1'b1;
            pixData    = pixTab[i];
            frameStart = (i == restartAt);
            @(posedge clock); #1;
            pixValid   = 1'b0;
            frameStart = 1'b0;
            for (int k = 1; k < spacing; k++) begin
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic waitFrameDone(input string name, input logic expOvf);
        int cycles = 0;
        while ((busy || expQueue.size() != 0) && cycles < 500) begin
            @(negedge clock);
            cycles++;
        end
        checkOutput({name, "_done"}, {31'b0, (cycles < 500)}, 32'd1);
        checkOutput({name, "_xfers"}, xferCount - frameBase, 32'd13);
        checkOutput({name, "_busy"}, {31'b0, busy}, 32'd0);
        checkOutput({name, "_overflow"}, {31'b0, overflow}, {31'b0, expOvf});
    endtask

    // Every presented beat must equal the scoreboard head, including while stalled.
    always @(negedge clock) begin
        if (reset_reset_n && src_valid) begin
            if (expQueue.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL unexpected_beat: got 0x%08h, expected no beat",
                         {src_startofpacket, src_endofpacket, src_data});
            end else begin
                checkOutput("beat", {src_startofpacket, src_endofpacket, src_data}, expQueue[0]);
                if (src_ready) begin
                    void'(expQueue.pop_front());
                    xferCount++;
                end
            end
        end
    end

    // Random mode never holds ready low for more than two cycles, so the FIFO cannot overflow.
    initial begin
        int zeroRun;
        zeroRun   = 0;
        src_ready = 1'b0;
        forever begin
            @(posedge clock); #1;
            case (readyMode)
                0: src_ready = 1'b1;
                2: src_ready = 1'b0;
                default: begin
                    if (zeroRun >= 2) src_ready = 1'b1;
                    else src_ready = 1'($urandom_range(0, 1));
                    zeroRun = src_ready ? 0 : zeroRun + 1;
                end
            endcase
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: bench did not finish, errors=%0d", errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        pixTab[0] = 16'hF800; expTab[0] = 30'h3FF00000;
        pixTab[1] = 16'h07E0; expTab[1] = 30'h000FFC00;
        pixTab[2] = 16'h001F; expTab[2] = 30'h000003FF;
        pixTab[3] = 16'hFFFF; expTab[3] = 30'h3FFFFFFF;
        pixTab[4] = 16'h0000; expTab[4] = 30'h00000000;
        pixTab[5] = 16'h8410; expTab[5] = 30'h21082210;
        pixTab[6] = 16'h1234; expTab[6] = 30'h04245294;
        pixTab[7] = 16'hA5A5; expTab[7] = 30'h294B6CA5;

        frameStart    = 1'b0;
        pixValid      = 1'b0;
        pixData       = 16'h0;
        reset_reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkIdle("reset");
        @(posedge clock); #1;
        reset_reset_n = 1'b1;

        $display("[TB] basic frame with colour expansion");
        frameBase = xferCount;
        pushFrame(1'b0);
        applyStimulus(1, -1);
        waitFrameDone("basic", 1'b0);

        $display("[TB] random backpressure");
        readyMode = 1;
        frameBase = xferCount;
        pushFrame(1'b0);
        applyStimulus(4, -1);
        waitFrameDone("backpressure", 1'b0);
        readyMode = 0;

        $display("[TB] overflow with sink stalled");
        readyMode = 2;
        frameBase = xferCount;
        pushFrame(1'b1);
        applyStimulus(1, -1);
        repeat (11) @(posedge clock);
        #1;
        checkOutput("ovf_sticky", {31'b0, overflow}, 32'd1);
        checkOutput("ovf_busy", {31'b0, busy}, 32'd1);
        readyMode = 0;
        waitFrameDone("overflow", 1'b1);

        $display("[TB] frame_start ignored mid-frame");
        frameBase = xferCount;
        pushFrame(1'b0);
        applyStimulus(1, 6);
        waitFrameDone("restart", 1'b0);
        repeat (10) @(negedge clock);
        checkOutput("restart_idle_busy", {31'b0, busy}, 32'd0);

        $display("[TB] reset in the middle of the video packet");
        frameBase = xferCount;
        pushFrame(1'b0);
        applyStimulus(1, -1);
        checkOutput("midpkt_busy", {31'b0, busy}, 32'd1);
        reset_reset_n = 1'b0;
        expQueue.delete();
        @(posedge clock);
        @(negedge clock);
        checkIdle("midpkt_reset");
        @(posedge clock); #1;
        reset_reset_n = 1'b1;

        $display("[TB] clean frame after reset");
        frameBase = xferCount;
        pushFrame(1'b0);
        applyStimulus(1, -1);
        waitFrameDone("after_reset", 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
